l2_mem_responder: RTL and testbench

Memory-side responder for the L2 cache: the slave end of the `mem_read`/`mem_write`/`mem_addr`/`mem_wdata`/`mem_rdata`/`mem_ready` block interface that the L2 cache drives. It latches one 128-bit block request at a time, waits a programmable latency, then performs the access on a block-addressed backing store and pulses `mem_ready` for one cycle. It serves as the main-memory model for system simulation and as the latency-accurate front of the memory subsystem.

---
 rtl/l2_mem_pkg.sv | 18 +
 rtl/mem_store_array.sv | 31 +++
 rtl/l2_mem_responder.sv | 151 +++++++++++++++
 tb/tb_l2_mem_responder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/l2_mem_pkg.sv
// Shared types and default widths for the L2 memory-side responder.
package l2_mem_pkg;

    localparam int unsigned ADDR_W = 28;
    localparam int unsigned DATA_W = 128;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } op_t;

endpackage

// File: rtl/mem_store_array.sv
// Single-port synchronous block store; read data only changes on a read,
// so it holds through writes and idle cycles. Contents are never reset.
module mem_store_array #(
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  i_en,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [DATA_W-1:0]     i_wdata,
    output logic [DATA_W-1:0]     o_rdata
);

    logic [DATA_W-1:0] r_mem [2**DEPTH_LOG2];
    logic [DATA_W-1:0] r_rdata;

    // One access per cycle: write when i_we, otherwise registered read.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/l2_mem_responder.sv
// Memory-side responder for the L2 block interface: latches one request,
// waits LATENCY cycles, accesses the backing store and pulses mem_ready.
module l2_mem_responder #(
    parameter int unsigned ADDR_W     = l2_mem_pkg::ADDR_W,
    parameter int unsigned DATA_W     = l2_mem_pkg::DATA_W,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              proto_err,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
);

    import l2_mem_pkg::*;

    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [7:0]            r_cnt;
    logic [7:0]            w_cnt_next;
    op_t                   r_op;
    logic [DEPTH_LOG2-1:0] r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic                  r_proto_err;
    logic [15:0]           r_rd_cnt;
    logic [15:0]           r_wr_cnt;
    logic                  r_rd_valid;

    logic                  w_req;
    logic                  w_rd_issue;
    logic                  w_wr_commit;
    logic [DEPTH_LOG2-1:0] w_st_addr;
    logic [DATA_W-1:0]     w_st_rdata;
    logic                  w_unused_addr_bits;

    assign w_req              = mem_read | mem_write;
    assign w_unused_addr_bits = ^mem_addr[ADDR_W-1:DEPTH_LOG2];

    // The IDLE sample cycle counts as the first latency cycle, so BUSY lasts
    // LATENCY-1 cycles and the store read is launched on the edge entering
    // RESP. With LATENCY=1 that edge is the sampling edge itself, hence the
    // read comes straight from the request inputs.
    assign w_rd_issue  = ((r_state == IDLE) && w_req && !mem_write && (LATENCY == 1))
                       || ((r_state == BUSY) && (r_cnt == 8'd1) && (r_op == OP_RD));
    assign w_wr_commit = (r_state == RESP) && (r_op == OP_WR);
    assign w_st_addr   = (r_state == IDLE) ? mem_addr[DEPTH_LOG2-1:0] : r_addr;

    mem_store_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_store (
        .clk     (clk),
        .i_en    (w_rd_issue | w_wr_commit),
        .i_we    (w_wr_commit),
        .i_addr  (w_st_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_st_rdata)
    );

    // State and latency counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_cnt_next   = LAT_M1;
                    w_state_next = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                w_cnt_next = r_cnt - 8'd1;
                if (r_cnt <= 8'd1) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Request latch; write wins when both strobes are sampled together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op    <= OP_RD;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if ((r_state == IDLE) && w_req) begin
            r_op    <= mem_write ? OP_WR : OP_RD;
            r_addr  <= mem_addr[DEPTH_LOG2-1:0];
            r_wdata <= mem_wdata;
        end
    end

    // Sticky protocol error, completion counters and read-data valid flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_proto_err <= 1'b0;
            r_rd_cnt    <= '0;
            r_wr_cnt    <= '0;
            r_rd_valid  <= 1'b0;
        end else begin
            if ((r_state == IDLE) && mem_read && mem_write) begin
                r_proto_err <= 1'b1;
            end
            if (w_rd_issue) begin
                r_rd_valid <= 1'b1;
            end
            if (r_state == RESP) begin
                if (r_op == OP_WR) begin
                    r_wr_cnt <= r_wr_cnt + 16'd1;
                end else begin
                    r_rd_cnt <= r_rd_cnt + 16'd1;
                end
            end
        end
    end

    // The store output register is uninitialised, so it is masked until the
    // first read after reset has loaded it.
    assign mem_rdata = r_rd_valid ? w_st_rdata : '0;
    assign mem_ready = (r_state == RESP);
    assign proto_err = r_proto_err;
    assign rd_count  = r_rd_cnt;
    assign wr_count  = r_wr_cnt;

endmodule

// File: tb/tb_l2_mem_responder.sv
// Directed bench for l2_mem_responder: one instance at LATENCY=8, one at
// LATENCY=1 for the minimum-latency and address-aliasing cases.
module tb_l2_mem_responder;

    localparam logic [127:0] D_BEEF = 128'h0123_4567_89AB_CDEF_CAFE_F00D_DEAD_BEEF;

    logic         clk = 1'b0;
    logic         reset_a;
    logic         reset_b;
    int           n_chk  = 0;
    int           n_pass = 0;
    int           cyc    = 0;

    logic         a_read, a_write, a_ready, a_proto;
    logic [27:0]  a_addr;
    logic [127:0] a_wdata, a_rdata;
    logic [15:0]  a_rdc, a_wrc;

    logic         b_read, b_write, b_ready, b_proto;
    logic [27:0]  b_addr;
    logic [127:0] b_wdata, b_rdata;
    logic [15:0]  b_rdc, b_wrc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    l2_mem_responder #(
        .ADDR_W     (28),
        .DATA_W     (128),
        .DEPTH_LOG2 (10),
        .LATENCY    (8)
    ) u_dut_a (
        .clk       (clk),
        .reset     (reset_a),
        .mem_read  (a_read),
        .mem_write (a_write),
        .mem_addr  (a_addr),
        .mem_wdata (a_wdata),
        .mem_rdata (a_rdata),
        .mem_ready (a_ready),
        .proto_err (a_proto),
        .rd_count  (a_rdc),
        .wr_count  (a_wrc)
    );

    l2_mem_responder #(
        .ADDR_W     (28),
        .DATA_W     (128),
        .DEPTH_LOG2 (10),
        .LATENCY    (1)
    ) u_dut_b (
        .clk       (clk),
        .reset     (reset_b),
        .mem_read  (b_read),
        .mem_write (b_write),
        .mem_addr  (b_addr),
        .mem_wdata (b_wdata),
        .mem_rdata (b_rdata),
        .mem_ready (b_ready),
        .proto_err (b_proto),
        .rd_count  (b_rdc),
        .wr_count  (b_wrc)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Call just after a rising edge; returns just after the edge ending the
    // ready cycle with the request dropped, so a follow-up may be driven at once.
    task automatic req_a(input logic rd, input logic wr, input logic [27:0] addr,
                         input logic [127:0] wd, input logic [127:0] exp_rd,
                         input string tag, output int t_ready);
        int n;
        a_read  = rd;
        a_write = wr;
        a_addr  = addr;
        a_wdata = wd;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (a_ready) break;
        end
        chk({tag, " latency"}, 128'(n), 128'd8);
        if (rd && !wr) chk({tag, " rdata"}, a_rdata, exp_rd);
        t_ready = cyc;
        @(posedge clk);
        #1;
        a_read  = 1'b0;
        a_write = 1'b0;
    endtask

    task automatic req_b(input logic rd, input logic wr, input logic [27:0] addr,
                         input logic [127:0] wd, input logic [127:0] exp_rd,
                         input string tag);
        int n;
        b_read  = rd;
        b_write = wr;
        b_addr  = addr;
        b_wdata = wd;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (b_ready) break;
        end
        chk({tag, " latency"}, 128'(n), 128'd1);
        if (rd && !wr) chk({tag, " rdata"}, b_rdata, exp_rd);
        @(posedge clk);
        #1;
        b_read  = 1'b0;
        b_write = 1'b0;
    endtask

    initial begin
        int   t1, t2, t3;
        logic seen;
        a_read = 0; a_write = 0; a_addr = '0; a_wdata = '0;
        b_read = 0; b_write = 0; b_addr = '0; b_wdata = '0;
        reset_a = 1'b1;
        reset_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_a = 1'b0;
        reset_b = 1'b0;

        @(negedge clk);
        chk("rst ready", 128'(a_ready), 128'd0);
        chk("rst rdata", a_rdata, '0);
        chk("rst proto", 128'(a_proto), 128'd0);
        chk("rst rd_count", 128'(a_rdc), 128'd0);
        chk("rst wr_count", 128'(a_wrc), 128'd0);

        // LATENCY=1 instance: next-cycle ready and 0x400 aliasing onto 0x000.
        @(posedge clk); #1;
        req_b(1'b0, 1'b1, 28'h0000400, 128'hAB, '0, "b wr 0x400");
        req_b(1'b1, 1'b0, 28'h0000000, '0, 128'hAB, "b rd alias 0x000");
        @(negedge clk);
        chk("b wr_count", 128'(b_wrc), 128'd1);
        chk("b rd_count", 128'(b_rdc), 128'd1);

        // Write then read back block 5.
        @(posedge clk); #1;
        req_a(1'b0, 1'b1, 28'h0000005, D_BEEF, '0, "wr 5", t1);
        @(negedge clk);
        chk("wr 5 single pulse", 128'(a_ready), 128'd0);
        chk("wr 5 wr_count", 128'(a_wrc), 128'd1);
        @(posedge clk); #1;
        req_a(1'b1, 1'b0, 28'h0000005, '0, D_BEEF, "rd 5", t1);
        repeat (3) @(negedge clk);
        chk("rd 5 rdata held", a_rdata, D_BEEF);
        chk("rd 5 rd_count", 128'(a_rdc), 128'd1);

        // Preload block 3, rdata must hold the last read across the write.
        @(posedge clk); #1;
        req_a(1'b0, 1'b1, 28'h0000003, 128'h333, '0, "wr 3", t1);
        @(negedge clk);
        chk("rdata held over write", a_rdata, D_BEEF);

        // Write-back then refill, the refill issued right after the ready pulse.
        @(posedge clk); #1;
        req_a(1'b0, 1'b1, 28'h0000009, 128'h999, '0, "wb 9", t1);
        req_a(1'b1, 1'b0, 28'h0000003, '0, 128'h333, "refill 3", t2);
        chk("b2b spacing", 128'(t2 - t1), 128'd9);
        @(negedge clk);
        chk("b2b wr_count", 128'(a_wrc), 128'd3);
        chk("b2b rd_count", 128'(a_rdc), 128'd2);

        // Read and write together: treated as write, sticky error.
        @(posedge clk); #1;
        req_a(1'b1, 1'b1, 28'h0000002, 128'h55, '0, "both 2", t3);
        @(negedge clk);
        chk("both proto", 128'(a_proto), 128'd1);
        chk("both wr_count", 128'(a_wrc), 128'd4);
        @(posedge clk); #1;
        req_a(1'b1, 1'b0, 28'h0000002, '0, 128'h55, "rd 2", t3);
        @(negedge clk);
        chk("proto sticky", 128'(a_proto), 128'd1);
        chk("rd 2 rd_count", 128'(a_rdc), 128'd3);

        // Reset in the 4th BUSY cycle of a write to block 7.
        @(posedge clk); #1;
        req_a(1'b0, 1'b1, 28'h0000007, 128'h11, '0, "wr 7 old", t3);
        a_write = 1'b1;
        a_addr  = 28'h0000007;
        a_wdata = 128'h22;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen |= a_ready;
        end
        reset_a = 1'b1;
        a_write = 1'b0;
        repeat (2) begin
            @(negedge clk);
            seen |= a_ready;
        end
        chk("mid rst ready", 128'(a_ready), 128'd0);
        chk("mid rst rdata", a_rdata, '0);
        chk("mid rst proto", 128'(a_proto), 128'd0);
        chk("mid rst rd_count", 128'(a_rdc), 128'd0);
        chk("mid rst wr_count", 128'(a_wrc), 128'd0);
        reset_a = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen |= a_ready;
        end
        chk("mid rst no ready", 128'(seen), 128'd0);
        @(posedge clk); #1;
        req_a(1'b1, 1'b0, 28'h0000007, '0, 128'h11, "rd 7 after rst", t3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
